spart_driver: RTL

- Processor-side initiator for the SPART register bus; drives the iocs/iorw/ioaddr/databus transactions that the SPART bus interface responds to.
- After reset it programs the baud divisor (DB low, then DB high) from br_cfg.
- It then polls status and echoes every received byte back out through the transmit buffer.
- Sits at the top level beside the SPART and serves as the stand-in processor for board bring-up.

---
 rtl/spart_pkg.sv | 37 +++
 rtl/spart_driver_if.sv | 13 +
 rtl/spart_driver.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/spart_pkg.sv
// Shared definitions for the SPART bus driver: register addresses,
// status bit positions, FSM state encoding and the baud divisor lookup.
package spart_pkg;

  // SPART register map as seen on ioaddr
  localparam logic [1:0] ADDR_BUF    = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DBL    = 2'b10;
  localparam logic [1:0] ADDR_DBH    = 2'b11;

  // Bit positions inside the status register
  localparam int unsigned RDA_BIT = 0;
  localparam int unsigned TBR_BIT = 1;

  typedef enum logic [2:0] {
    INIT_LO,
    INIT_HI,
    RX_POLL,
    RX_READ,
    TX_POLL,
    TX_WRITE
  } state_t;

  // Baud divisor for a 16x oversampling receiver: clk/(16*baud) - 1
  function automatic logic [15:0] divisor(input logic [1:0] br_cfg,
                                          input int unsigned clk_freq);
    int unsigned baud;
    case (br_cfg)
      2'b00:   baud = 4800;
      2'b01:   baud = 9600;
      2'b10:   baud = 19200;
      default: baud = 38400;
    endcase
    return 16'(clk_freq / (16 * baud) - 1);
  endfunction

endpackage

// File: rtl/spart_driver_if.sv
// Control half of the SPART register bus (chip select, direction, address).
// The shared data lines stay a plain inout port on the driver so the
// tristate resolves at module level.
interface spart_driver_if #(
  parameter int unsigned ADDR_W = 2
);
  logic              iocs;
  logic              iorw;
  logic [ADDR_W-1:0] ioaddr;

  modport master (output iocs, output iorw, output ioaddr);
  modport slave  (input  iocs, input  iorw, input  ioaddr);
endinterface

// File: rtl/spart_driver.sv
// Stand-in processor for SPART bring-up: programs the baud divisor, then
// polls status and echoes each received byte back through the tx buffer.
// Optional macro SPART_DRV_UPCASE_EN: echo lowercase ASCII as uppercase.
module spart_driver
  import spart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned ADDR_W   = 2,
  parameter int unsigned DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        br_cfg,
  spart_driver_if.master    bus,
  inout  wire logic [DATA_W-1:0] databus,
  output logic [DATA_W-1:0] rx_byte,
  output logic              echo_pulse
);

  state_t            state;
  state_t            state_nxt;
  logic              active;
  logic [1:0]        cfg_q;
  logic              pending;
  logic              mismatch;
  logic              reconfig;
  logic [15:0]       div_cur;
  logic [7:0]        div_hi_q;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] wdata;
  logic              iocs_d;
  logic              iorw_d;
  logic [ADDR_W-1:0] addr_d;

  assign div_cur  = divisor(cfg_q, CLK_FREQ);
  assign mismatch = (br_cfg != cfg_q);
  // A change seen this cycle is acted on immediately, not one poll later
  assign reconfig = pending | mismatch;

`ifdef SPART_DRV_UPCASE_EN
  assign tx_data = (rx_byte >= DATA_W'(8'h61) && rx_byte <= DATA_W'(8'h7A))
                 ? rx_byte - DATA_W'(8'h20) : rx_byte;
`else
  assign tx_data = rx_byte;
`endif

  // State register; 'active' holds the bus idle for the cycle after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= INIT_LO;
      active <= 1'b0;
    end else begin
      state  <= state_nxt;
      active <= 1'b1;
    end
  end

  // Baud config tracking; a new mismatch wins over the INIT_LO clear
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q   <= br_cfg;
      pending <= 1'b0;
    end else if (mismatch) begin
      cfg_q   <= br_cfg;
      pending <= 1'b1;
    end else if (active && state == INIT_LO) begin
      pending <= 1'b0;
    end
  end

  // High divisor byte frozen with the low write so both halves match
  always_ff @(posedge clk) begin
    if (rst) begin
      div_hi_q <= '0;
    end else if (state == INIT_LO) begin
      div_hi_q <= div_cur[15:8];
    end
  end

  // Receive capture at the edge that ends the buffer read
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_byte <= '0;
    end else if (state == RX_READ) begin
      rx_byte <= databus;
    end
  end

  // Next-state selection from the current read data
  always_comb begin
    state_nxt = state;
    if (active) begin
      case (state)
        INIT_LO:  state_nxt = INIT_HI;
        INIT_HI:  state_nxt = RX_POLL;
        RX_POLL: begin
          if (reconfig)              state_nxt = INIT_LO;
          else if (databus[RDA_BIT]) state_nxt = RX_READ;
        end
        RX_READ:  state_nxt = TX_POLL;
        TX_POLL:  if (databus[TBR_BIT]) state_nxt = TX_WRITE;
        TX_WRITE: state_nxt = reconfig ? INIT_LO : RX_POLL;
        default:  state_nxt = INIT_LO;
      endcase
    end
  end

  // Bus cycle decode from the state register
  always_comb begin
    iocs_d     = 1'b0;
    iorw_d     = 1'b1;
    addr_d     = '0;
    wdata      = '0;
    echo_pulse = 1'b0;
    if (active) begin
      iocs_d = 1'b1;
      case (state)
        INIT_LO: begin
          iorw_d = 1'b0;
          addr_d = ADDR_W'(ADDR_DBL);
          wdata  = DATA_W'(div_cur[7:0]);
        end
        INIT_HI: begin
          iorw_d = 1'b0;
          addr_d = ADDR_W'(ADDR_DBH);
          wdata  = DATA_W'(div_hi_q);
        end
        RX_POLL, TX_POLL: addr_d = ADDR_W'(ADDR_STATUS);
        RX_READ:          addr_d = ADDR_W'(ADDR_BUF);
        TX_WRITE: begin
          iorw_d     = 1'b0;
          addr_d     = ADDR_W'(ADDR_BUF);
          wdata      = tx_data;
          echo_pulse = 1'b1;
        end
        default: iocs_d = 1'b0;
      endcase
    end
  end

  assign bus.iocs   = iocs_d;
  assign bus.iorw   = iorw_d;
  assign bus.ioaddr = addr_d;

  assign databus = (iocs_d && !iorw_d) ? wdata : 'z;

endmodule
